// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_SHIFT = 2'd1;
    localparam state_t S_DONE  = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from two chained half subtractors.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs_ab (
        .A    (A),
        .B    (B),
        .Diff (d1),
        .Bout (b1)
    );

    // Second stage subtracts the incoming borrow from the partial difference.
    half_subtractor u_hs_bin (
        .A    (d1),
        .B    (Bin),
        .Diff (Diff),
        .Bout (b2)
    );

    assign Bout = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// One-bit half subtractor: Diff = A - B, Bout set when A < B.
module half_subtractor (
    input  logic A,
    input  logic B,
    output logic Diff,
    output logic Bout
);

    assign Diff = A ^ B;
    assign Bout = ~A & B;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B, LSB first, one bit per clock,
// with a start/busy/done handshake.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bor
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t         state;
    state_t         state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic           bor;
    logic [CW-1:0]  count;
    logic           d;
    logic           bnext;
    logic           last;

    assign last = (count == CW'(WIDTH - 1));

    full_subtractor u_fs (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Bin  (bor),
        .Diff (d),
        .Bout (bnext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_SHIFT;
            S_SHIFT: if (last)  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_SHIFT);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            bor   <= 1'b0;
            count <= '0;
            Diff  <= '0;
            Bor   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        res   <= '0;
                        bor   <= 1'b0;
                        count <= '0;
                    end
                end
                S_SHIFT: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    res   <= {d, res[WIDTH-1:1]};
                    bor   <= bnext;
                    count <= count + CW'(1);
                    // Publish on the final bit so Diff/Bor are valid during DONE.
                    if (last) begin
                        Diff <= {d, res[WIDTH-1:1]};
                        Bor  <= bnext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=4.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bor8;
    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       bor4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .busy  (busy8),
        .done  (done8),
        .Diff  (diff8),
        .Bor   (bor8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .A     (a4),
        .B     (b4),
        .busy  (busy4),
        .done  (done4),
        .Diff  (diff4),
        .Bor   (bor4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one WIDTH=8 operation from IDLE and wait for its done pulse.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] d, output logic bo,
                        output int done_at, output int busy_cnt,
                        output logic pulse_again);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        tick();
        start8 = 1'b0;
        a8 = ~a;
        b8 = ~b;
        done_at = -1;
        busy_cnt = 0;
        d = 'x;
        bo = 1'bx;
        for (int c = 0; c < 20; c++) begin
            if (busy8) busy_cnt++;
            if (done8) begin
                done_at = c;
                d = diff8;
                bo = bor8;
                break;
            end
            tick();
        end
        tick();
        pulse_again = done8;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] d, output logic bo, output int done_at);
        start4 = 1'b1;
        a4 = a;
        b4 = b;
        tick();
        start4 = 1'b0;
        done_at = -1;
        d = 'x;
        bo = 1'bx;
        for (int c = 0; c < 12; c++) begin
            if (done4) begin
                done_at = c;
                d = diff4;
                bo = bor4;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        a8 = '0;
        b8 = '0;
        a4 = '0;
        b4 = '0;
        tick();
        tick();
        checks++;
        if ({busy8, done8, diff8, bor8} !== 11'b0) begin
            errors++;
            $display("FAIL reset_w8: got busy=%b done=%b diff=%h bor=%b expected all zero",
                     busy8, done8, diff8, bor8);
        end
        checks++;
        if ({busy4, done4, diff4, bor4} !== 7'b0) begin
            errors++;
            $display("FAIL reset_w4: got busy=%b done=%b diff=%h bor=%b expected all zero",
                     busy4, done4, diff4, bor4);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic bo;
        logic pa;
        int da;
        int bc;
        run8(8'h35, 8'h12, d, bo, da, bc, pa);
        checks++;
        if (d !== 8'h23 || bo !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got diff=%h bor=%b expected diff=23 bor=0", d, bo);
        end
        checks++;
        if (da !== 8) begin
            errors++;
            $display("FAIL basic_latency: got done %0d cycles after busy start, expected 8", da);
        end
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("FAIL basic_busy_len: got %0d busy cycles expected 8", bc);
        end
        checks++;
        if (pa !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%b one cycle later expected 0", pa);
        end
    endtask

    task automatic test_borrow();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic [7:0] td [3];
        logic       tbo [3];
        logic [7:0] d;
        logic bo;
        logic pa;
        int da;
        int bc;
        ta = '{8'h12, 8'h00, 8'hFF};
        tb = '{8'h35, 8'h01, 8'hFF};
        td = '{8'hDD, 8'hFF, 8'h00};
        tbo = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run8(ta[i], tb[i], d, bo, da, bc, pa);
            checks++;
            if (d !== td[i] || bo !== tbo[i] || da !== 8) begin
                errors++;
                $display("FAIL borrow_%0d: got diff=%h bor=%b at %0d expected diff=%h bor=%b at 8",
                         i, d, bo, da, td[i], tbo[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int da = -1;
        start8 = 1'b1;
        a8 = 8'h80;
        b8 = 8'h01;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        start8 = 1'b1;
        a8 = 8'h00;
        b8 = 8'hFF;
        for (int c = 2; c < 20; c++) begin
            if (done8) begin
                da = c;
                break;
            end
            tick();
        end
        checks++;
        if (da !== 8 || diff8 !== 8'h7F || bor8 !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_first: got diff=%h bor=%b at %0d expected diff=7f bor=0 at 8",
                     diff8, bor8, da);
        end
        tick();
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_idle: got busy=%b done=%b expected 0 0 after done", busy8, done8);
        end
        tick();
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || diff8 !== 8'h7F) begin
            errors++;
            $display("FAIL busy_restart: got busy=%b diff=%h expected busy=1 diff=7f held", busy8, diff8);
        end
        da = -1;
        for (int c = 0; c < 20; c++) begin
            if (done8) begin
                da = c;
                break;
            end
            tick();
        end
        checks++;
        if (da !== 8 || diff8 !== 8'h01 || bor8 !== 1'b1) begin
            errors++;
            $display("FAIL busy_second: got diff=%h bor=%b at %0d expected diff=01 bor=1 at 8",
                     diff8, bor8, da);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int dcount = 0;
        logic [7:0] d;
        logic bo;
        logic pa;
        int da;
        int bc;
        start8 = 1'b1;
        a8 = 8'hAA;
        b8 = 8'h55;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy8, done8, diff8, bor8} !== 11'b0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b diff=%h bor=%b expected all zero",
                     busy8, done8, diff8, bor8);
        end
        for (int c = 0; c < 15; c++) begin
            if (done8 || busy8) dcount++;
            tick();
        end
        checks++;
        if (dcount !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d active cycles after abort expected 0", dcount);
        end
        run8(8'hAA, 8'h55, d, bo, da, bc, pa);
        checks++;
        if (d !== 8'h55 || bo !== 1'b0 || da !== 8) begin
            errors++;
            $display("FAIL reset_fresh: got diff=%h bor=%b at %0d expected diff=55 bor=0 at 8", d, bo, da);
        end
    endtask

    task automatic test_random8();
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic [7:0] exp_d;
        logic bo;
        logic pa;
        int da;
        int bc;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom);
            b = (i % 6 == 0) ? a : 8'($urandom);
            exp_d = 8'((int'(a) - int'(b)) & 8'hFF);
            run8(a, b, d, bo, da, bc, pa);
            checks++;
            if (d !== exp_d || bo !== (a < b) || da !== 8) begin
                errors++;
                $display("FAIL random8 %h-%h: got diff=%h bor=%b at %0d expected diff=%h bor=%b at 8",
                         a, b, d, bo, da, exp_d, (a < b));
            end
        end
    endtask

    task automatic test_sweep4();
        logic [3:0] d;
        logic [3:0] exp_d;
        logic bo;
        int da;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                exp_d = 4'((a - b) & 4'hF);
                run4(4'(a), 4'(b), d, bo, da);
                checks++;
                if (d !== exp_d || bo !== (a < b) || da !== 4) begin
                    errors++;
                    $display("FAIL sweep4 %0d-%0d: got diff=%h bor=%b at %0d expected diff=%h bor=%b at 4",
                             a, b, d, bo, da, exp_d, (a < b));
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_start_while_busy();
        test_reset_mid();
        test_random8();
        test_sweep4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
